// File: rtl/mdu_sequencer_if.sv
// ============================================================================
// Module      : mdu_sequencer_if
// Description : EX/D-stage control, operand and HI/LO result bundle for the
//               multiply/divide sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mdu_sequencer_if;
    logic        Start;
    logic        MDSign;
    logic        MD;
    logic        HLWrite;
    logic [31:0] A;
    logic [31:0] B;
    logic        Cancel;
    logic        MDUse;
    logic        Busy;
    logic        Stall;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output Start, MDSign, MD, HLWrite, A, B, Cancel, MDUse,
        input  Busy, Stall, HI, LO
    );

    modport slave (
        input  Start, MDSign, MD, HLWrite, A, B, Cancel, MDUse,
        output Busy, Stall, HI, LO
    );
endinterface

`default_nettype wire

// File: rtl/mdu_sequencer.sv
// ============================================================================
// Module      : mdu_sequencer
// Description : Fixed-latency mult/div sequencer owning the HI/LO registers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  wire               clk,
    input  wire               reset_n,
    mdu_sequencer_if.slave    bus
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

    logic [0:0]  state_q,  state_d;
    logic [3:0]  cnt_q,    cnt_d;
    logic [31:0] res_hi_q, res_hi_d;
    logic [31:0] res_lo_q, res_lo_d;
    logic [31:0] hi_q,     hi_d;
    logic [31:0] lo_q,     lo_d;

    logic [63:0] mul_a, mul_b, product;
    logic        neg_a, neg_b;
    logic [31:0] abs_a, abs_b, q_mag, r_mag;
    logic [31:0] quot, rem;
    logic [31:0] calc_hi, calc_lo;

    // Result datapath: evaluated every cycle, captured only when a Start is accepted
    always_comb begin
        mul_a   = {{32{bus.MDSign & bus.A[31]}}, bus.A};
        mul_b   = {{32{bus.MDSign & bus.B[31]}}, bus.B};
        product = mul_a * mul_b;

        neg_a = bus.MDSign & bus.A[31];
        neg_b = bus.MDSign & bus.B[31];
        abs_a = neg_a ? (32'd0 - bus.A) : bus.A;
        abs_b = neg_b ? (32'd0 - bus.B) : bus.B;
        q_mag = 32'd0;
        r_mag = 32'd0;
        if (abs_b != 32'd0) begin
            q_mag = abs_a / abs_b;
            r_mag = abs_a % abs_b;
        end
        quot = (neg_a ^ neg_b) ? (32'd0 - q_mag) : q_mag;
        rem  = neg_a ? (32'd0 - r_mag) : r_mag;

        if (!bus.MD) begin
            calc_hi = product[63:32];
            calc_lo = product[31:0];
        end else if (bus.B == 32'd0) begin
            calc_hi = bus.A;
            calc_lo = 32'hFFFF_FFFF;
        end else if (bus.MDSign && bus.A == 32'h8000_0000 && bus.B == 32'hFFFF_FFFF) begin
            calc_hi = 32'd0;
            calc_lo = 32'h8000_0000;
        end else begin
            calc_hi = rem;
            calc_lo = quot;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            IDLE: begin
                if (bus.Cancel) begin
                    state_d = IDLE;
                end else if (bus.Start) begin
                    res_hi_d = calc_hi;
                    res_lo_d = calc_lo;
                    cnt_d    = bus.MD ? DIV_LOAD : MULT_LOAD;
                    state_d  = RUN;
                end else if (bus.HLWrite) begin
                    if (bus.MD) lo_d = bus.A;
                    else        hi_d = bus.A;
                end
            end
            RUN: begin
                // A cancel on the final edge still wins over the commit
                if (bus.Cancel) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    hi_d    = res_hi_q;
                    lo_d    = res_lo_q;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            res_hi_q <= 32'd0;
            res_lo_q <= 32'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign bus.Busy  = (state_q == RUN);
    assign bus.Stall = bus.MDUse && ((state_q == RUN) || bus.Start);
    assign bus.HI    = hi_q;
    assign bus.LO    = lo_q;

`ifndef SYNTHESIS
    a_no_issue_while_run : assert property (
        @(posedge clk) disable iff (!reset_n)
        (state_q == RUN) |-> !(bus.Start || bus.HLWrite)
    );
`endif

endmodule

`default_nettype wire

// File: tb/tb_mdu_sequencer.sv
// ============================================================================
// Module      : tb_mdu_sequencer
// Description : Scoreboard bench for mdu_sequencer with a longint reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mdu_sequencer;

    localparam int MULT_C = 5;
    localparam int DIV_C  = 10;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          len;
        string       nm;
    } exp_t;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;
    exp_t sb_q[$];
    logic [31:0] model_hi, model_lo;
    int   busy_len;
    bit   busy_prev;

    mdu_sequencer_if bus ();

    mdu_sequencer #(
        .MULT_CYCLES (MULT_C),
        .DIV_CYCLES  (DIV_C)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: 64-bit integer arithmetic straight from the mult/div rules
    task automatic ref_md(input bit dv, input bit sg, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] hi, output logic [31:0] lo);
        longint x, y, p, q, r;
        x = sg ? longint'($signed(a)) : longint'({32'd0, a});
        y = sg ? longint'($signed(b)) : longint'({32'd0, b});
        if (!dv) begin
            p  = x * y;
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == 32'd0) begin
            hi = a;
            lo = 32'hFFFF_FFFF;
        end else begin
            q  = x / y;
            r  = x % y;
            hi = r[31:0];
            lo = q[31:0];
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.Start = 0; bus.MDSign = 0; bus.MD = 0; bus.HLWrite = 0;
        bus.A = 0; bus.B = 0; bus.Cancel = 0; bus.MDUse = 0;
    endtask

    task automatic start_op(input bit dv, input bit sg, input logic [31:0] a, input logic [31:0] b,
                            input bit chk_stall, input string nm);
        logic [31:0] eh, el;
        int n;
        ref_md(dv, sg, a, b, eh, el);
        n = dv ? DIV_C : MULT_C;
        sb_q.push_back('{hi: eh, lo: el, len: n, nm: nm});
        bus.Start = 1; bus.MD = dv; bus.MDSign = sg; bus.A = a; bus.B = b; bus.MDUse = chk_stall;
        #1;
        if (chk_stall) check({nm, "_stall_t0"}, {31'd0, bus.Stall}, 32'd1);
        step();
        bus.Start = 0; bus.A = $urandom; bus.B = $urandom;
        for (int i = 1; i <= n; i++) begin
            #1;
            if (chk_stall) check({nm, "_stall_busy"}, {31'd0, bus.Stall}, 32'd1);
            step();
        end
        #1;
        if (chk_stall) begin
            check({nm, "_stall_done"}, {31'd0, bus.Stall}, 32'd0);
            check({nm, "_lo_read"}, bus.LO, el);
        end
        bus.MDUse = 0;
        model_hi = eh;
        model_lo = el;
    endtask

    task automatic hl_write(input bit md, input logic [31:0] a, input bit cancel, input string nm);
        bus.HLWrite = 1; bus.MD = md; bus.A = a; bus.Cancel = cancel;
        step();
        bus.HLWrite = 0; bus.Cancel = 0;
        if (!cancel) begin
            if (md) model_lo = a;
            else    model_hi = a;
        end
        check({nm, "_hi"}, bus.HI, model_hi);
        check({nm, "_lo"}, bus.LO, model_lo);
    endtask

    task automatic cancel_op(input bit dv, input logic [31:0] a, input logic [31:0] b,
                             input int k, input string nm);
        sb_q.push_back('{hi: model_hi, lo: model_lo, len: k, nm: nm});
        bus.Start = 1; bus.MD = dv; bus.MDSign = 1; bus.A = a; bus.B = b;
        step();
        bus.Start = 0;
        for (int i = 1; i < k; i++) step();
        bus.Cancel = 1;
        step();
        bus.Cancel = 0;
        check({nm, "_busy_after"}, {31'd0, bus.Busy}, 32'd0);
    endtask

    // Monitor: every Busy falling edge is a completed (or aborted) operation
    initial begin
        busy_len  = 0;
        busy_prev = 0;
        forever begin
            @(negedge clk);
            if (bus.Busy === 1'b1) begin
                busy_len++;
            end else if (busy_prev) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got busy_len %0d expected no operation", busy_len);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check({e.nm, "_hi"}, bus.HI, e.hi);
                    check({e.nm, "_lo"}, bus.LO, e.lo);
                    check({e.nm, "_busy_len"}, 32'(busy_len), 32'(e.len));
                end
                busy_len = 0;
            end
            busy_prev = (bus.Busy === 1'b1);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks   = 0;
        errors   = 0;
        model_hi = 0;
        model_lo = 0;
        reset_n  = 0;
        idle_inputs();
        bus.Start = 1; bus.MDUse = 1;
        #3;
        check("rst_hi", bus.HI, 32'd0);
        check("rst_lo", bus.LO, 32'd0);
        check("rst_busy", {31'd0, bus.Busy}, 32'd0);
        check("rst_stall_start", {31'd0, bus.Stall}, 32'd1);
        bus.Start = 0;
        #1;
        check("rst_stall_nostart", {31'd0, bus.Stall}, 32'd0);
        bus.MDUse = 0;
        @(posedge clk);
        #1 reset_n = 1;
        step();

        start_op(0, 0, 32'hFFFF_FFFF, 32'd2, 0, "multu_max");
        check("multu_hi_const", bus.HI, 32'd1);
        check("multu_lo_const", bus.LO, 32'hFFFF_FFFE);
        start_op(0, 1, -32'sd3, 32'd7, 0, "mult_neg");
        start_op(1, 1, -32'sd7, 32'd2, 0, "div_neg");
        check("div_lo_const", bus.LO, 32'hFFFF_FFFD);
        check("div_hi_const", bus.HI, 32'hFFFF_FFFF);
        start_op(1, 0, 32'd9, 32'd0, 0, "divu_zero");
        start_op(1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
        check("ovf_lo_const", bus.LO, 32'h8000_0000);
        start_op(0, 1, 32'd1234567, -32'sd89, 1, "mult_stall");

        hl_write(0, 32'h1234, 0, "mthi");
        cancel_op(1, 32'd100, 32'd7, 4, "div_cancel");
        check("cancel_hi_kept", bus.HI, 32'h1234);
        step();

        sb_q.push_back('{hi: 32'd0, lo: 32'd0, len: 2, nm: "mult_reset"});
        bus.Start = 1; bus.MD = 0; bus.MDSign = 1; bus.A = 32'd77; bus.B = 32'd99;
        step();
        bus.Start = 0;
        step();
        step();
        reset_n = 0;
        #1;
        check("midrst_hi", bus.HI, 32'd0);
        check("midrst_lo", bus.LO, 32'd0);
        check("midrst_busy", {31'd0, bus.Busy}, 32'd0);
        model_hi = 0;
        model_lo = 0;
        step();
        reset_n = 1;
        step();
        hl_write(1, 32'hA5A5_A5A5, 1, "mtlo_cancel");

        for (int i = 0; i < 24; i++) begin
            bit dv, sg;
            logic [31:0] a, b;
            int sel;
            dv = 1'($urandom_range(0, 1));
            sg = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
            sel = $urandom_range(0, 7);
            case (sel)
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'($urandom_range(1, 20));
                default: b = 32'($urandom);
            endcase
            if ($urandom_range(0, 3) == 0)
                hl_write(1'($urandom_range(0, 1)), 32'($urandom), 0, "rnd_mthl");
            start_op(dv, sg, a, b, 1'($urandom_range(0, 1)), "rnd_op");
            repeat ($urandom_range(0, 2)) step();
        end

        repeat (3) step();
        check("queue_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
